div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one iterative `div` unit between `NREQ` requesters, such as several executer lanes or harts, using round-robin arbitration. It latches the winning request's operands and sequences the divider's kick/ready handshake. It then selects quotient or remainder according to the request's op and returns the result to the owning requester as a one-cycle response. It sits between the executers and a single `div` instance, replacing per-executer dividers.

## Interface
- `NREQ`, default 2: number of requesters, from 2 to 8.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: one-hot accept. A transfer occurs when `req_valid[i] && req_ready[i]`. Combinational from state, `req_valid` and the RR pointer.
- `req_op` in NREQ×4: div op per requester, using `DIV_DIV`, `DIV_REM` or other values.
- `req_unsigned` in NREQ: unsigned flag per requester.
- `req_a` in NREQ×32: dividend per requester.
- `req_b` in NREQ×32: divisor per requester.
- `rsp_valid` out NREQ: one-hot, one-cycle response pulse to the owner.
- `rsp_pre` out NREQ: `div_ready_pre` routed to the current owner; zero for all others.
- `rsp_result` out 32: result, meaningful only while `rsp_valid` is nonzero.
- `rsp_unknown_op` out 1: set with `rsp_valid` when the op was neither DIV nor REM.
- `busy` out 1: high whenever state is not IDLE.
- `div_kick` out 1: divider start pulse.
- `div_unsigned_flag` out 1: latched unsigned flag driven to the divider.
- `div_dividend` out 32: latched dividend driven to the divider.
- `div_divider` out 32: latched divisor driven to the divider.
- `div_ready` in 1: divider result ready.
- `div_ready_pre` in 1: divider early-ready indication.
- `div_quotient` in 32: divider quotient.
- `div_remainder` in 32: divider remainder.

## Operation
- States are IDLE, KICK, WAIT and RESP.
- **IDLE:** grant goes to the first requester with `req_valid` high, searching from `last_grant+1` mod NREQ upward. `req_ready` is all-zero in every state other than IDLE.
- **On accept:**
  - Latch owner index, op, `a`, `b` and unsigned flag; set `last_grant` to the owner.
  - If op is `DIV_DIV` or `DIV_REM`: set `div_kick`=1 and go to KICK.
  - Otherwise: set `rsp_result`=0 and `rsp_unknown_op`=1, go directly to RESP, and never kick the divider.
- **KICK:** set `div_kick`=0 and go to WAIT.
- **WAIT:** sample `div_ready` every cycle. On the first cycle it is high:
  - Register `rsp_result` as quotient for DIV or remainder for REM.
  - Set `rsp_unknown_op`=0 and go to RESP.
- **RESP:** `rsp_valid[owner]`=1 for this single cycle, then go to IDLE. A new request is not accepted in RESP.
- **Outputs:**
  - `div_dividend`, `div_divider` and `div_unsigned_flag` hold their latched values from accept until the next accept.
  - `rsp_pre[owner]` follows `div_ready_pre` only in WAIT; it is 0 in every other state and for every non-owner.
- **Boundary conditions:**
  - A requester may drop `req_valid` before it is granted; nothing is recorded.
  - Operand changes on `req_*` after accept have no effect.
  - Requests arriving while busy wait; they are not dropped.
  - Divide-by-zero and overflow results are whatever `div` produces; they pass through unchanged.
  - `reset` in any state returns the block to IDLE and suppresses any pending response.
- **Reset values:** state IDLE, `last_grant`=NREQ-1 (requester 0 wins first), `div_kick`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_unknown_op`=0, operand registers 0, owner 0.

## Timing
- Accept occurs in cycle T.
- `div_kick`=1 during T+1 (KICK), then 0 from T+2.
- Divider contract: `div_ready` is low no later than the first cycle after kick deasserts. The arbiter therefore samples it from T+2.
- If `div_ready` is first seen high in cycle R, then `rsp_valid`=1 during R+1.
- Earliest possible next accept is R+2.
- Unknown op: accept in T, `rsp_valid` in T+1, next accept possible in T+2.
- Per-requester service latency is bounded by (NREQ−1) full transactions plus its own.

## Structure
- Shared package `core_pkg` holds the `DIV_NOP`/`DIV_DIV`/`DIV_REM` codes, as already used by the executer, and the `div_arb_state_t` enum {IDLE, KICK, WAIT, RESP}.
- Sub-module `rr_arbiter` (parameter N): inputs `req[N]` and `last[$clog2(N)]`; outputs one-hot `gnt[N]` and `gnt_idx`. It is purely combinational.
- The `div` instance is external. Connect it to the `div_*` ports.

## Test plan
- req0 DIV, 100/7, signed → `div_kick` pulses once at T+1; `rsp_valid[0]` pulses with result 14 and `rsp_unknown_op`=0.
- req1 REM, 100/7 → result 2. Signed DIV −7/2 (0xFFFFFFF9 / 2) → result 0xFFFFFFFD.
- `req_valid`=2'b11 in the same cycle right after reset → req0 served first, req1 accepted in the first IDLE cycle after req0's RESP; responses in that order.
- Both requesters held valid for 6 transactions → grants alternate 0,1,0,1,0,1. No accept occurs in a RESP cycle.
- req0 op=4'hF → `rsp_valid[0]` at T+1 with `rsp_unknown_op`=1 and result 0; `div_kick` stays 0 throughout.
- `reset` asserted during WAIT → next cycle state is IDLE, `busy`=0 and no `rsp_valid` appears. A fresh req1 afterwards completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: divider op codes and the divider arbiter state encoding.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_OP_W = 4;

    typedef logic [DIV_OP_W-1:0] div_op_t;

    // Op codes already used by the executer.
    localparam div_op_t DIV_NOP = 4'h0;
    localparam div_op_t DIV_DIV = 4'h1;
    localparam div_op_t DIV_REM = 4'h2;

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        WAIT,
        RESP
    } div_arb_state_t;

    // True for the ops that actually need the divider.
    function automatic logic is_div_op(input div_op_t op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    int   cand;
    logic found;

    // Walk last+1 .. last+N (mod N) and take the first active request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand[IW-1:0];
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NREQ requesters with round-robin arbitration,
// sequences the kick/ready handshake and returns quotient or remainder to the owner.
module div_arbiter
    import core_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ-1:0][DIV_OP_W-1:0]     req_op,
    input  logic [NREQ-1:0]                   req_unsigned,
    input  logic [NREQ-1:0][XLEN-1:0]         req_a,
    input  logic [NREQ-1:0][XLEN-1:0]         req_b,

    output logic [NREQ-1:0]                   rsp_valid,
    output logic [NREQ-1:0]                   rsp_pre,
    output logic [XLEN-1:0]                   rsp_result,
    output logic                              rsp_unknown_op,
    output logic                              busy,

    output logic                              div_kick,
    output logic                              div_unsigned_flag,
    output logic [XLEN-1:0]                   div_dividend,
    output logic [XLEN-1:0]                   div_divider,
    input  logic                              div_ready,
    input  logic                              div_ready_pre,
    input  logic [XLEN-1:0]                   div_quotient,
    input  logic [XLEN-1:0]                   div_remainder
);

    localparam int IW = $clog2(NREQ);

    div_arb_state_t  state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    div_op_t         op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            uns_q, uns_d;
    logic            kick_q, kick_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            unknown_q, unknown_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            accept;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .last    (last_grant_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Only IDLE offers a grant; the arbiter output is already zero when nobody asks.
    assign accept    = (state_q == IDLE) && (|req_valid);
    assign req_ready = (state_q == IDLE) ? gnt : '0;

    // Next-state and next-register computation for the arbitration sequence.
    always_comb begin
        // NOTE: every *_d starts from its *_q (or an idle value) so no branch leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        uns_d        = uns_q;
        result_d     = result_q;
        unknown_d    = unknown_q;
        kick_d       = 1'b0;
        rsp_valid_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = gnt_idx;
                    last_grant_d = gnt_idx;
                    op_d         = req_op[gnt_idx];
                    a_d          = req_a[gnt_idx];
                    b_d          = req_b[gnt_idx];
                    uns_d        = req_unsigned[gnt_idx];
                    if (is_div_op(req_op[gnt_idx])) begin
                        kick_d  = 1'b1;
                        state_d = KICK;
                    end else begin
                        // Unsupported op: answer immediately without touching the divider.
                        result_d             = '0;
                        unknown_d            = 1'b1;
                        rsp_valid_d[gnt_idx] = 1'b1;
                        state_d              = RESP;
                    end
                end
            end
            KICK: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_ready) begin
                    result_d             = (op_q == DIV_DIV) ? div_quotient : div_remainder;
                    unknown_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            owner_q      <= '0;
            op_q         <= DIV_NOP;
            a_q          <= '0;
            b_q          <= '0;
            uns_q        <= 1'b0;
            kick_q       <= 1'b0;
            result_q     <= '0;
            unknown_q    <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            uns_q        <= uns_d;
            kick_q       <= kick_d;
            result_q     <= result_d;
            unknown_q    <= unknown_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Early-ready is only meaningful to the owner while the divider is running.
    always_comb begin
        rsp_pre = '0;
        if (state_q == WAIT) begin
            rsp_pre[owner_q] = div_ready_pre;
        end
    end

    assign busy              = (state_q != IDLE);
    assign div_kick          = kick_q;
    assign div_unsigned_flag = uns_q;
    assign div_dividend      = a_q;
    assign div_divider       = b_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_result        = result_q;
    assign rsp_unknown_op    = unknown_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider and a spec-level reference model.
module tb_div_arbiter;
    import core_pkg::*;

    localparam int NREQ = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][3:0]      req_op;
    logic [NREQ-1:0]           req_unsigned;
    logic [NREQ-1:0][31:0]     req_a;
    logic [NREQ-1:0][31:0]     req_b;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_pre;
    logic [31:0]               rsp_result;
    logic                      rsp_unknown_op;
    logic                      busy;
    logic                      div_kick;
    logic                      div_unsigned_flag;
    logic [31:0]               div_dividend;
    logic [31:0]               div_divider;
    logic                      div_ready = 1'b0;
    logic                      div_ready_pre;
    logic [31:0]               div_quotient = '0;
    logic [31:0]               div_remainder = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_force = 0;
    int div_cnt = 0;

    div_arbiter #(.NREQ(NREQ)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_unsigned      (req_unsigned),
        .req_a             (req_a),
        .req_b             (req_b),
        .rsp_valid         (rsp_valid),
        .rsp_pre           (rsp_pre),
        .rsp_result        (rsp_result),
        .rsp_unknown_op    (rsp_unknown_op),
        .busy              (busy),
        .div_kick          (div_kick),
        .div_unsigned_flag (div_unsigned_flag),
        .div_dividend      (div_dividend),
        .div_divider       (div_divider),
        .div_ready         (div_ready),
        .div_ready_pre     (div_ready_pre),
        .div_quotient      (div_quotient),
        .div_remainder     (div_remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider semantics: x/0 -> all ones rem x; signed MIN/-1 -> MIN rem 0; otherwise truncating division.
    function automatic logic [63:0] ref_div(input logic uns, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'h0;
        end else if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {q, r};
    endfunction

    // Expected response {unknown_op, result} for one request.
    function automatic logic [32:0] expect_rsp(input logic [3:0] op, input logic uns,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] qr;
        qr = ref_div(uns, a, b);
        if (op == DIV_DIV) return {1'b0, qr[63:32]};
        if (op == DIV_REM) return {1'b0, qr[31:0]};
        return {1'b1, 32'h0};
    endfunction

    // Behavioural iterative divider: random latency, ready drops right after the kick.
    always @(posedge clk) begin
        if (div_kick) begin
            {div_quotient, div_remainder} <= ref_div(div_unsigned_flag, div_dividend, div_divider);
            div_cnt   <= (lat_force != 0) ? lat_force : int'($urandom_range(1, 6));
            div_ready <= 1'b0;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) div_ready <= 1'b1;
        end
    end
    assign div_ready_pre = (div_cnt == 1);

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rand_req(input int i);
        int sel;
        sel = int'($urandom_range(0, 9));
        req_op[i]       = (sel == 0) ? 4'hF : (sel < 6) ? DIV_DIV : DIV_REM;
        req_unsigned[i] = 1'($urandom_range(0, 1));
        req_a[i]        = $urandom;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0: req_b[i] = 32'h0;
            1: begin req_a[i] = 32'h8000_0000; req_b[i] = 32'hFFFF_FFFF; end
            2, 3: req_b[i] = 32'($urandom_range(1, 20));
            default: req_b[i] = $urandom;
        endcase
    endtask

    // One isolated transaction from requester i, checking the full cycle-level protocol.
    task automatic run_txn(input int i, input logic [3:0] op, input logic uns, input logic [31:0] a,
                           input logic [31:0] b, input string name, output logic [31:0] got);
        logic [32:0]     ex;
        logic            known;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] want_pre;
        int              w_acc;
        int              r_k;
        int              exp_k;
        bit              seen;
        bit              done;
        ex    = expect_rsp(op, uns, a, b);
        known = (op == DIV_DIV) || (op == DIV_REM);
        oh    = '0;
        oh[i] = 1'b1;
        got   = '0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_op[i] = op; req_unsigned[i] = uns; req_a[i] = a; req_b[i] = b;
        w_acc = -1;
        for (int w = 0; w < 20 && w_acc < 0; w++) begin
            @(negedge clk);
            if (req_ready != '0) w_acc = w;
        end
        checks++;
        if (w_acc < 0 || req_ready !== oh) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b expected %b", name, req_ready, oh);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0; req_a[i] = ~a; req_b[i] = b + 32'd1; req_op[i] = ~op; req_unsigned[i] = ~uns;
        seen = 1'b0; done = 1'b0; r_k = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            checks++;
            if (div_kick !== (known && k == 1)) begin
                errors++;
                $display("FAIL %s kick @T+%0d: got %b expected %b", name, k, div_kick, known && k == 1);
            end
            if (k == 1) begin
                checks++;
                if ({div_unsigned_flag, div_dividend, div_divider} !== {uns, a, b}) begin
                    errors++;
                    $display("FAIL %s operands: got %b/%h/%h expected %b/%h/%h", name,
                             div_unsigned_flag, div_dividend, div_divider, uns, a, b);
                end
            end
            want_pre = (known && k >= 2 && !seen && div_ready_pre) ? oh : '0;
            checks++;
            if (rsp_pre !== want_pre) begin
                errors++;
                $display("FAIL %s rsp_pre @T+%0d: got %b expected %b", name, k, rsp_pre, want_pre);
            end
            if (rsp_valid != '0) begin
                done  = 1'b1;
                got   = rsp_result;
                exp_k = known ? r_k + 1 : 1;
                checks++;
                if (k != exp_k || (known && !seen)) begin
                    errors++;
                    $display("FAIL %s rsp timing: at T+%0d expected T+%0d", name, k, exp_k);
                end
                checks++;
                if (rsp_valid !== oh) begin
                    errors++;
                    $display("FAIL %s rsp owner: got %b expected %b", name, rsp_valid, oh);
                end
                checks++;
                if ({rsp_unknown_op, rsp_result} !== ex) begin
                    errors++;
                    $display("FAIL %s result: got unk=%b %h expected unk=%b %h", name,
                             rsp_unknown_op, rsp_result, ex[32], ex[31:0]);
                end
            end else if (known && k >= 2 && !seen && div_ready) begin
                seen = 1'b1;
                r_k  = k;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no rsp_valid within 60 cycles", name);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after resp: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_op = '0; req_unsigned = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, div_kick, rsp_valid, rsp_pre, req_ready, rsp_unknown_op} !== '0) begin
            errors++;
            $display("FAIL reset ctrl: busy=%b kick=%b rsp_valid=%b pre=%b ready=%b unk=%b expected all 0",
                     busy, div_kick, rsp_valid, rsp_pre, req_ready, rsp_unknown_op);
        end
        checks++;
        if ({rsp_result, div_dividend, div_divider, div_unsigned_flag} !== '0) begin
            errors++;
            $display("FAIL reset data: result=%h dividend=%h divisor=%h uns=%b expected 0",
                     rsp_result, div_dividend, div_divider, div_unsigned_flag);
        end
    endtask

    task automatic test_div_basic();
        logic [31:0] got;
        run_txn(0, DIV_DIV, 1'b0, 32'd100, 32'd7, "div_100_7", got);
        checks++;
        if (got !== 32'd14) begin errors++; $display("FAIL div_100_7 value: got %h expected 0000000e", got); end
        run_txn(1, DIV_REM, 1'b0, 32'd100, 32'd7, "rem_100_7", got);
        checks++;
        if (got !== 32'd2) begin errors++; $display("FAIL rem_100_7 value: got %h expected 00000002", got); end
        run_txn(0, DIV_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, "div_m7_2", got);
        checks++;
        if (got !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 value: got %h expected fffffffd", got); end
        run_txn(1, DIV_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, "divu_big_2", got);
        checks++;
        if (got !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big_2 value: got %h expected 7ffffffc", got); end
        run_txn(0, DIV_DIV, 1'b0, 32'd55, 32'd0, "div_by_zero", got);
    endtask

    task automatic test_unknown_op();
        logic [31:0] got;
        run_txn(0, 4'hF, 1'b0, 32'd123, 32'd45, "unknown_op", got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("FAIL unknown_op value: got %h expected 00000000", got); end
    endtask

    // Both requesters valid from the first cycle after reset: grants alternate, responses in order.
    task automatic test_back_to_back();
        int          exp_idx_q[$];
        logic [32:0] exp_rsp_q[$];
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] want;
        int n_acc;
        int n_rsp;
        int last_rsp_cyc;
        int j;
        do_reset();
        rand_req(0);
        rand_req(1);
        req_valid = '1;
        n_acc = 0; n_rsp = 0; last_rsp_cyc = -10;
        for (int c = 0; c < 400 && n_rsp < 6; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (busy) begin
                checks++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL b2b ready while busy: got %b expected 0", req_ready);
                end
            end
            if (rsp_valid != '0) begin
                checks++;
                if (exp_idx_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b spurious rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
                end else begin
                    want = '0;
                    want[exp_idx_q[0]] = 1'b1;
                    if (rsp_valid !== want || {rsp_unknown_op, rsp_result} !== exp_rsp_q[0]) begin
                        errors++;
                        $display("FAIL b2b rsp %0d: got %b unk=%b %h expected %b unk=%b %h", n_rsp,
                                 rsp_valid, rsp_unknown_op, rsp_result, want, exp_rsp_q[0][32], exp_rsp_q[0][31:0]);
                    end
                    void'(exp_idx_q.pop_front());
                    void'(exp_rsp_q.pop_front());
                end
                n_rsp++;
                last_rsp_cyc = cyc;
            end
            if (acc != '0) begin
                want = '0;
                want[n_acc % 2] = 1'b1;
                checks++;
                if (acc !== want) begin
                    errors++;
                    $display("FAIL b2b grant %0d: got %b expected %b", n_acc, acc, want);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (cyc != last_rsp_cyc + 1) begin
                        errors++;
                        $display("FAIL b2b accept gap: accept cycle %0d expected %0d", cyc, last_rsp_cyc + 1);
                    end
                end
                j = acc[1] ? 1 : 0;
                exp_idx_q.push_back(j);
                exp_rsp_q.push_back(expect_rsp(req_op[j], req_unsigned[j], req_a[j], req_b[j]));
                n_acc++;
                @(posedge clk); #1;
                if (n_acc >= 6) req_valid = '0;
                else rand_req(j);
            end
        end
        checks++;
        if (n_acc != 6 || n_rsp != 6) begin
            errors++;
            $display("FAIL b2b counts: accepts=%0d responses=%0d expected 6/6", n_acc, n_rsp);
        end
    endtask

    // A requester that withdraws before being granted leaves no trace.
    task automatic test_drop();
        int  got_rsp;
        int  w;
        logic [32:0] ex;
        lat_force = 8;
        @(posedge clk); #1;
        req_op[0] = DIV_REM; req_unsigned[0] = 1'b1; req_a[0] = 32'd1000; req_b[0] = 32'd7;
        ex = expect_rsp(DIV_REM, 1'b1, 32'd1000, 32'd7);
        req_valid[0] = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (req_ready[0] !== 1'b1 && w < 20);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 req_valid[1] = 1'b0;
        got_rsp = 0;
        for (int c = 0; c < 40 && got_rsp == 0; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got_rsp = 1;
                checks++;
                if (rsp_valid !== 2'b01 || {rsp_unknown_op, rsp_result} !== ex) begin
                    errors++;
                    $display("FAIL drop rsp: got %b unk=%b %h expected 01 unk=%b %h",
                             rsp_valid, rsp_unknown_op, rsp_result, ex[32], ex[31:0]);
                end
            end
        end
        checks++;
        if (got_rsp == 0) begin errors++; $display("FAIL drop timeout: no response for req0"); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL drop ghost: busy=%b ready=%b expected 0/00", busy, req_ready);
            end
        end
        lat_force = 0;
    endtask

    // Reset mid-divide returns to IDLE and swallows the pending response.
    task automatic test_reset_in_wait();
        logic [31:0] got;
        int w;
        bit spurious;
        lat_force = 20;
        @(posedge clk); #1;
        req_op[0] = DIV_DIV; req_unsigned[0] = 1'b0; req_a[0] = 32'd1000; req_b[0] = 32'd3;
        req_valid[0] = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (req_ready[0] !== 1'b1 && w < 20);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || div_kick !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait state: busy=%b rsp_valid=%b kick=%b expected 0", busy, rsp_valid, div_kick);
        end
        spurious = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL reset_wait leak: response or busy seen after reset"); end
        lat_force = 0;
        run_txn(1, DIV_REM, 1'b0, 32'd1000, 32'd3, "after_reset_req1", got);
        checks++;
        if (got !== 32'd1) begin errors++; $display("FAIL after_reset_req1 value: got %h expected 00000001", got); end
    endtask

    task automatic test_random();
        logic [31:0] got;
        int i;
        for (int n = 0; n < 20; n++) begin
            i = int'($urandom_range(0, NREQ - 1));
            rand_req(i);
            run_txn(i, req_op[i], req_unsigned[i], req_a[i], req_b[i], "random", got);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_unknown_op();
        test_back_to_back();
        test_drop();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
